// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt controller.
package intr_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } intr_state_t;

  typedef enum logic {
    SRC_KEY,
    SRC_ETH
  } intr_src_t;

  // Chooses which pending source to present next.
  function automatic intr_src_t pick_src(logic pend_key, logic pend_eth, logic eth_priority);
    if (pend_eth && (eth_priority || !pend_key)) begin
      return SRC_ETH;
    end
    return SRC_KEY;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser and debouncer; emits a one-cycle pulse on an accepted press.
module key_debounce #(
  parameter int unsigned DebounceCycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flip;

  assign flip    = (sync2_q != level_q) && (cnt_q == CntMax);
  // Only the low-to-high flip counts; releases are silent.
  assign press_o = flip && !level_q;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (flip) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: captures key and Ethernet events and presents one at a time to the core.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned DebounceCycles = 16,
  parameter bit          EthPriority    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              key_raw_i,
  input  logic [DATA_W-1:0] key_data_i,
  input  logic              eth_valid_i,
  input  logic [DATA_W-1:0] eth_data_i,
  input  logic              int_enable_i,
  input  logic              int_ack_i,
  input  logic              int_done_i,
  output logic              interrupt_key_o,
  output logic              interrupt_eth_o,
  output logic [DATA_W-1:0] interrupt_source_data_o,
  output logic              busy_o,
  output logic              ovf_key_o,
  output logic              ovf_eth_o
);

  logic              key_press;
  logic              pend_key_q, pend_key_d, pend_eth_q, pend_eth_d;
  logic              ovf_key_q, ovf_key_d, ovf_eth_q, ovf_eth_d;
  logic [DATA_W-1:0] key_hold_q, key_hold_d, eth_hold_q, eth_hold_d;
  intr_state_t       state_q;
  intr_src_t         sel_q, next_src;
  logic              irq_key_q, irq_eth_q, busy_q;
  logic [DATA_W-1:0] data_q;
  logic              ack_fire, clr_key, clr_eth;

  key_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_key_debounce (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .key_raw_i(key_raw_i),
    .press_o  (key_press)
  );

  assign ack_fire = (state_q == REQ) && int_ack_i;
  assign clr_key  = ack_fire && (sel_q == SRC_KEY);
  assign clr_eth  = ack_fire && (sel_q == SRC_ETH);
  assign next_src = pick_src(pend_key_q, pend_eth_q, EthPriority);

  // Clear precedes set, so an event landing on its own ack re-arms cleanly.
  always_comb begin
    pend_key_d = pend_key_q;
    key_hold_d = key_hold_q;
    ovf_key_d  = ovf_key_q;
    pend_eth_d = pend_eth_q;
    eth_hold_d = eth_hold_q;
    ovf_eth_d  = ovf_eth_q;
    if (clr_key) pend_key_d = 1'b0;
    if (clr_eth) pend_eth_d = 1'b0;
    if (key_press) begin
      if (pend_key_q && !clr_key) begin
        ovf_key_d = 1'b1;
      end else begin
        pend_key_d = 1'b1;
        key_hold_d = key_data_i;
      end
    end
    if (eth_valid_i) begin
      if (pend_eth_q && !clr_eth) begin
        ovf_eth_d = 1'b1;
      end else begin
        pend_eth_d = 1'b1;
        eth_hold_d = eth_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_key_q <= 1'b0;
      pend_eth_q <= 1'b0;
      ovf_key_q  <= 1'b0;
      ovf_eth_q  <= 1'b0;
      key_hold_q <= '0;
      eth_hold_q <= '0;
    end else begin
      pend_key_q <= pend_key_d;
      pend_eth_q <= pend_eth_d;
      ovf_key_q  <= ovf_key_d;
      ovf_eth_q  <= ovf_eth_d;
      key_hold_q <= key_hold_d;
      eth_hold_q <= eth_hold_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sel_q     <= SRC_KEY;
      irq_key_q <= 1'b0;
      irq_eth_q <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (int_enable_i && (pend_key_q || pend_eth_q)) begin
            state_q   <= REQ;
            busy_q    <= 1'b1;
            sel_q     <= next_src;
            irq_key_q <= (next_src == SRC_KEY);
            irq_eth_q <= (next_src == SRC_ETH);
            data_q    <= (next_src == SRC_ETH) ? eth_hold_q : key_hold_q;
          end
        end
        REQ: begin
          if (int_ack_i) begin
            state_q   <= SERVICE;
            irq_key_q <= 1'b0;
            irq_eth_q <= 1'b0;
          end else if (!int_enable_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            irq_key_q <= 1'b0;
            irq_eth_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (int_done_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          irq_key_q <= 1'b0;
          irq_eth_q <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt_key_o         = irq_key_q;
  assign interrupt_eth_o         = irq_eth_q;
  assign interrupt_source_data_o = data_q;
  assign busy_o                  = busy_q;
  assign ovf_key_o               = ovf_key_q;
  assign ovf_eth_o               = ovf_eth_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: a pending-set model predicts presentation order and data.
module tb_intr_ctrl;
  import intr_pkg::*;

  localparam int unsigned Deb = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        key_raw = 1'b0;
  logic [31:0] key_data = '0;
  logic        eth_valid = 1'b0;
  logic [31:0] eth_data = '0;
  logic        int_enable = 1'b0;
  logic        int_ack = 1'b0;
  logic        int_done = 1'b0;
  logic        irq_key, irq_eth, busy, ovf_key, ovf_eth;
  logic [31:0] src_data;

  always #5 clk = ~clk;

  intr_ctrl #(
    .DebounceCycles(Deb),
    .EthPriority   (1'b1)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .key_raw_i              (key_raw),
    .key_data_i             (key_data),
    .eth_valid_i            (eth_valid),
    .eth_data_i             (eth_data),
    .int_enable_i           (int_enable),
    .int_ack_i              (int_ack),
    .int_done_i             (int_done),
    .interrupt_key_o        (irq_key),
    .interrupt_eth_o        (irq_eth),
    .interrupt_source_data_o(src_data),
    .busy_o                 (busy),
    .ovf_key_o              (ovf_key),
    .ovf_eth_o              (ovf_eth)
  );

  typedef struct {
    bit          is_eth;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  // Model state, index 0 = key, 1 = eth.
  bit          m_pend[2];
  logic [31:0] m_hold[2];
  bit          m_ovf[2];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  function automatic void model_event(int s, logic [31:0] d);
    if (m_pend[s]) begin
      m_ovf[s] = 1'b1;
    end else begin
      m_pend[s] = 1'b1;
      m_hold[s] = d;
    end
  endfunction

  // Presents everything pending in priority order (Ethernet first).
  function automatic int model_flush();
    int   n = 0;
    exp_t e;
    while (m_pend[0] || m_pend[1]) begin
      e.is_eth  = m_pend[1];
      e.data    = m_hold[e.is_eth ? 1 : 0];
      m_pend[e.is_eth ? 1 : 0] = 1'b0;
      exp_q.push_back(e);
      n++;
    end
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 1'b0;
      m_hold[i] = '0;
      m_ovf[i]  = 1'b0;
    end
  endfunction

  // Monitor: every newly raised request line is checked against the scoreboard.
  logic prev_k = 1'b0, prev_e = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    check("onehot", 32'(irq_key & irq_eth), 32'd0);
    if ((irq_key && !prev_k) || (irq_eth && !prev_e)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_req: got key=%b eth=%b data=%h, required no request",
                 irq_key, irq_eth, src_data);
      end else begin
        e = exp_q.pop_front();
        check("req_src_eth", 32'(irq_eth), 32'(e.is_eth));
        check("req_data", src_data, e.data);
      end
    end
    prev_k <= irq_key;
    prev_e <= irq_eth;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic eth_pulse(logic [31:0] d);
    eth_data  = d;
    eth_valid = 1'b1;
    tick();
    eth_valid = 1'b0;
  endtask

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = irq_key || irq_eth;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_req: got no request within 200 cycles, required a request");
    end
  endtask

  task automatic service(int d1, int d2);
    wait_req();
    repeat (d1) @(negedge clk);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("ack_drops_line", 32'(irq_key | irq_eth), 32'd0);
    check("busy_in_service", 32'(busy), 32'd1);
    tick(d2);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    check("done_clears_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_idle_outputs(string name);
    check({name, "_key"}, 32'(irq_key), 32'd0);
    check({name, "_eth"}, 32'(irq_eth), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] d, d2;
    model_reset();
    rst_ni = 1'b0;
    tick(3);
    check_idle_outputs("reset");
    check("reset_data", src_data, 32'd0);
    check("reset_ovf", {30'd0, ovf_key, ovf_eth}, 32'd0);
    rst_ni = 1'b1;
    int_enable = 1'b1;
    tick(2);

    // Ethernet event latency and handshake.
    model_event(1, 32'hDEADBEEF);
    n = model_flush();
    eth_pulse(32'hDEADBEEF);
    check("eth_latency_early", 32'(irq_eth), 32'd0);
    tick();
    check("eth_latency_line", 32'(irq_eth), 32'd1);
    check("eth_latency_data", src_data, 32'hDEADBEEF);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("eth_ack_line", 32'(irq_eth), 32'd0);
    check("eth_ack_data_held", src_data, 32'hDEADBEEF);
    tick(2);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    check("eth_done_busy", 32'(busy), 32'd0);

    // Debounced key press, then a short glitch that must be filtered.
    key_data = 32'h5;
    key_raw  = 1'b1;
    model_event(0, 32'h5);
    n = model_flush();
    service(1, 1);
    key_raw = 1'b0;
    tick(30);
    key_raw = 1'b1;
    tick(5);
    key_raw = 1'b0;
    tick(40);
    check_idle_outputs("glitch");

    // Both pending while disabled: nothing until enabled, then Ethernet first.
    int_enable = 1'b0;
    key_data   = 32'h0000_0A0A;
    key_raw    = 1'b1;
    tick(30);
    key_raw = 1'b0;
    tick(30);
    eth_pulse(32'h0000_0E0E);
    model_event(0, 32'h0000_0A0A);
    model_event(1, 32'h0000_0E0E);
    tick(5);
    check_idle_outputs("disabled");
    int_enable = 1'b1;
    n = model_flush();
    for (int i = 0; i < n; i++) service(0, 1);

    // Event on the source being acked in the same cycle re-arms without overflow.
    model_event(1, 32'hA1);
    n = model_flush();
    eth_pulse(32'hA1);
    wait_req();
    int_ack   = 1'b1;
    eth_valid = 1'b1;
    eth_data  = 32'hB2;
    model_event(1, 32'hB2);
    tick();
    int_ack   = 1'b0;
    eth_valid = 1'b0;
    check("same_cycle_no_ovf", 32'(ovf_eth), 32'd0);
    tick();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    n = model_flush();
    service(1, 0);

    // Enable dropped during REQ: line falls, request is reissued with the same data.
    model_event(1, 32'hC3);
    n = model_flush();
    exp_q.push_back(exp_q[exp_q.size() - 1]);
    eth_pulse(32'hC3);
    wait_req();
    int_enable = 1'b0;
    tick();
    check("disable_drops_line", 32'(irq_eth), 32'd0);
    check("disable_busy", 32'(busy), 32'd0);
    tick(3);
    check("disable_stays_low", 32'(irq_eth), 32'd0);
    int_enable = 1'b1;
    service(0, 1);

    // Ack wins over a simultaneous disable.
    model_event(1, 32'hD4);
    n = model_flush();
    eth_pulse(32'hD4);
    wait_req();
    int_ack    = 1'b1;
    int_enable = 1'b0;
    tick();
    int_ack    = 1'b0;
    int_enable = 1'b1;
    check("ack_wins_busy", 32'(busy), 32'd1);
    tick(2);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    tick(5);
    check_idle_outputs("ack_wins_idle");

    // Second Ethernet event before ack overflows and keeps the first data.
    check("ovf_eth_before", 32'(ovf_eth), 32'd0);
    model_event(1, 32'h1);
    model_event(1, 32'h2);
    n = model_flush();
    eth_pulse(32'h1);
    eth_pulse(32'h2);
    service(1, 1);
    tick(10);
    check("ovf_eth_set", 32'(ovf_eth), 32'(m_ovf[1]));
    check_idle_outputs("ovf_single");

    // Randomised traffic.
    for (int it = 0; it < 25; it++) begin
      d  = $urandom;
      d2 = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          model_event(1, d);
          n = model_flush();
          eth_pulse(d);
          service(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        1: begin
          key_data = d;
          key_raw  = 1'b1;
          model_event(0, d);
          n = model_flush();
          service(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          key_raw = 1'b0;
          tick(30);
        end
        2: begin
          int_enable = 1'b0;
          key_data   = d;
          key_raw    = 1'b1;
          tick(30);
          key_raw = 1'b0;
          tick(30);
          model_event(0, d);
          eth_pulse(d2);
          model_event(1, d2);
          if ($urandom_range(0, 1) == 1) begin
            eth_pulse(d2 ^ 32'hFFFF);
            model_event(1, d2 ^ 32'hFFFF);
          end
          tick(3);
          check_idle_outputs("rand_disabled");
          int_enable = 1'b1;
          n = model_flush();
          for (int i = 0; i < n; i++) begin
            service(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          end
        end
        default: begin
          model_event(1, d);
          model_event(1, d2);
          n = model_flush();
          eth_pulse(d);
          eth_pulse(d2);
          service(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
      endcase
      tick(2);
    end
    check("rand_ovf_eth", 32'(ovf_eth), 32'(m_ovf[1]));
    check("rand_ovf_key", 32'(ovf_key), 32'(m_ovf[0]));

    // Asynchronous reset while in SERVICE, then normal operation resumes.
    model_event(1, 32'h77);
    n = model_flush();
    eth_pulse(32'h77);
    wait_req();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_data", src_data, 32'd0);
    check("async_reset_ovf", {30'd0, ovf_key, ovf_eth}, 32'd0);
    model_reset();
    tick(2);
    rst_ni = 1'b1;
    tick(2);
    model_event(1, 32'h88);
    n = model_flush();
    eth_pulse(32'h88);
    service(0, 0);

    tick(20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller that sequences external events into the processor's `interrupt_key` / `interrupt_eth` / `interrupt_source_data` inputs.
- Captures raw key presses (synchronised and debounced) and Ethernet receive events, holds them as pending, and presents one at a time by priority.
- Uses a request/acknowledge/done handshake with the core, so no interrupt is lost or nested.
- Sits between board I/O / the Ethernet receiver and `proc`.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a key level change is accepted (board build overrides to 500000).
- ETH_PRIORITY, 1, 1 = Ethernet wins over key when both are pending; 0 = key wins.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_raw  in  1  asynchronous push-button level, active-high.
- key_data  in  32  value sampled as key source data at the accepted press.
- eth_valid  in  1  one-cycle strobe, Ethernet word received.
- eth_data  in  32  Ethernet word, valid with eth_valid.
- int_enable  in  1  global interrupt enable from the core.
- int_ack  in  1  core has vectored the presented interrupt (one-cycle pulse).
- int_done  in  1  core has returned from the handler (one-cycle pulse).
- interrupt_key  out  1  key interrupt request to the core.
- interrupt_eth  out  1  Ethernet interrupt request to the core.
- interrupt_source_data  out  32  data of the presented source.
- busy  out  1  high in REQ or SERVICE.
- ovf_key  out  1  sticky: key event dropped.
- ovf_eth  out  1  sticky: Ethernet event dropped.

Behaviour:
- Reset: all outputs 0, pending bits 0, holding registers 0, FSM in IDLE, debounce counter 0, debounced level 0. Reset is asynchronous and may be applied mid-REQ or mid-SERVICE; everything returns to reset values.
- All outputs are registered.

Key path:
- 2-FF synchroniser on key_raw.
- Debounce counter resets whenever the synchronised level equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
- A 0->1 flip of the debounced level is a key event. At that edge key_data is latched into key_hold and pend_key is set.
- Releases (1->0 flips) generate nothing.

Ethernet path:
- eth_valid sampled high sets pend_eth and latches eth_data into eth_hold on the same edge.

Overflow:
- An event for a source whose pend bit is already set, and not being cleared this cycle, sets the matching ovf_* bit.
- The holding register keeps the first event's data. The new data is discarded.
- ovf_* bits clear only on reset.

FSM (states IDLE, REQ, SERVICE):
- IDLE:
  - If int_enable and any pend bit is set, select the source by ETH_PRIORITY, go to REQ.
  - On the same edge, drive the selected interrupt_* line high and load interrupt_source_data from that source's hold register.
  - Latency: eth_valid sampled at edge N -> pend at N -> interrupt_eth high after edge N+1.
- REQ:
  - The selected line stays high and interrupt_source_data stays stable.
  - int_ack -> clear the selected pend bit, drop the line, go to SERVICE. interrupt_source_data is held until the next REQ.
  - int_enable low without int_ack -> drop the line, return to IDLE, pend bit kept.
  - int_ack and int_enable low in the same cycle: ack wins.
  - The selected source is frozen in REQ. A higher-priority event arriving during REQ only sets its pend bit.
- SERVICE:
  - Lines low. int_done -> IDLE.
  - The next request can assert no earlier than the edge after the one returning to IDLE, giving a one-cycle gap.
- Ignored inputs: int_ack outside REQ; int_done outside SERVICE.
- Event for the source being acked in the same cycle: the clear happens, then the set. Net result: pend stays 1, the new data is latched, no overflow.
- At most one interrupt_* line is high at any time.

Decomposition:
- Package intr_pkg:
  - state enum intr_state_t {IDLE, REQ, SERVICE};
  - source enum intr_src_t {SRC_KEY, SRC_ETH};
  - localparam DATA_W = 32.
- Sub-module key_debounce (synchroniser + counter + rising-edge pulse), parameterised by DEBOUNCE_CYCLES. It outputs a one-cycle press pulse.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES)+1.

Test Plan:
- Reset, int_enable=1, eth_valid pulse with eth_data=32'hDEADBEEF -> interrupt_eth=1 and interrupt_source_data=32'hDEADBEEF two edges later. int_ack -> line 0 next edge. int_done -> busy=0.
- key_raw high for 20 cycles, key_data=32'h5, DEBOUNCE_CYCLES=16 -> interrupt_key asserts; a 5-cycle glitch pulse on key_raw produces no interrupt.
- Key and eth events in the same cycle, ETH_PRIORITY=1 -> eth presented first. After ack+done, key presented with its data; interrupt_key and interrupt_eth never high together.
- Two eth_valid pulses (32'h1 then 32'h2) before any ack -> ovf_eth=1, presented data 32'h1, single interrupt.
- int_enable=0 with an event pending -> no line asserted. Drop int_enable during REQ -> line drops, pending kept. Re-enable -> request reissued with the same data.
- Assert rst_n=0 while in SERVICE -> all outputs 0 immediately (asynchronous). A new eth event after reset is serviced normally.
